// File: rtl/config_loader.sv
// Byte-stream config loader: assembles DATA_W/8 bytes MSB-first, writes the config register once, then checks the read-back.
// Optional build macro CFG_LOADER_TIMEOUT_EN drops a partial word after TIMEOUT_CYCLES idle cycles.
`timescale 1ns/1ps

module config_loader #(
  parameter int DATA_W         = 32,
  parameter int ERR_CNT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 cfg_wen,
  output logic [DATA_W-1:0]    cfg_data,
  input  logic [DATA_W-1:0]    cfg_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 ok,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  if ((DATA_W % 8) != 0 || DATA_W < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("config_loader: DATA_W must be a positive multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    Collect,
    Write,
    Check
  } state_t;

  state_t                 state_q;
  logic [IdxW-1:0]        byteIdx_q;
  logic [DATA_W-1:0]      word_q;
  logic [DATA_W-1:0]      word_d;
  logic [DATA_W-1:0]      cfgData_q;
  logic                   byteReady_q;
  logic                   cfgWen_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ok_q;
  logic [ERR_CNT_W-1:0]   errCnt_q;
  logic                   accept;

`ifdef CFG_LOADER_TIMEOUT_EN
  localparam int ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] IdleLast = ToW'(TIMEOUT_CYCLES - 1);
  logic [ToW-1:0] idle_q;
`endif

  function automatic logic [ERR_CNT_W-1:0] satInc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // byteReady_q is high exactly while in Collect, so it doubles as the accept qualifier
  assign accept = byte_valid && byteReady_q;
  assign word_d = (word_q << 8) | DATA_W'(byte_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= Collect;
      byteIdx_q   <= '0;
      word_q      <= '0;
      cfgData_q   <= '0;
      byteReady_q <= 1'b1;
      cfgWen_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      errCnt_q    <= '0;
`ifdef CFG_LOADER_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      cfgWen_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        Collect: begin
          if (accept) begin
            word_q <= word_d;
`ifdef CFG_LOADER_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (byteIdx_q == LastIdx) begin
              byteIdx_q   <= '0;
              cfgData_q   <= word_d;
              cfgWen_q    <= 1'b1;
              byteReady_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= Write;
            end else begin
              byteIdx_q <= byteIdx_q + 1'b1;
            end
          end
`ifdef CFG_LOADER_TIMEOUT_EN
          else if (byteIdx_q != '0) begin
            // abandoned partial word: report it like a rejected write, without touching the register
            if (idle_q == IdleLast) begin
              idle_q    <= '0;
              byteIdx_q <= '0;
              word_q    <= '0;
              done_q    <= 1'b1;
              ok_q      <= 1'b0;
              errCnt_q  <= satInc(errCnt_q);
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
`endif
        end
        Write: begin
          state_q <= Check;
        end
        Check: begin
          ok_q        <= (cfg_rdata == cfgData_q);
          done_q      <= 1'b1;
          if (cfg_rdata != cfgData_q) begin
            errCnt_q <= satInc(errCnt_q);
          end
          byteReady_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= Collect;
        end
        default: begin
          state_q <= Collect;
        end
      endcase
    end
  end

  assign byte_ready = byteReady_q;
  assign cfg_wen    = cfgWen_q;
  assign cfg_data   = cfgData_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ok         = ok_q;
  assign err_cnt    = errCnt_q;

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Host-side writer for the 32-bit config register.
- Accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into one configuration word.
- Issues a single-cycle write strobe to the config register, then reads back the register output to confirm the write took effect.
- Sits between the external configuration source and the config register; reports per-word done/ok status and a saturating reject count.

Parameters:
DATA_W, 32, config word width; must be a multiple of 8
NBYTES, DATA_W/8, bytes per word (derived, not overridden)
ERR_CNT_W, 8, width of the reject counter
TIMEOUT_CYCLES, 255, inter-byte idle limit (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
byte_in  in  8  incoming configuration byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  loader can accept a byte this cycle
cfg_wen  out  1  write enable to the config register
cfg_data  out  DATA_W  write data to the config register
cfg_rdata  in  DATA_W  config register output (read-back)
busy  out  1  loader is in WRITE or CHECK
done  out  1  one-cycle pulse: word write attempt finished
ok  out  1  result of last attempt; valid when done=1, held until the next done
err_cnt  out  ERR_CNT_W  saturating count of rejected writes

Behaviour:
- Reset (rst=0, async): state=COLLECT, byte index=0, shift register=0.
  - Output reset values: cfg_wen=0, cfg_data=0, done=0, ok=0, err_cnt=0, busy=0, byte_ready=1 once rst releases.
- States and transitions:
  - COLLECT:
    - byte_ready=1; a byte is accepted on a rising edge with byte_valid=1.
    - Each accepted byte is shifted into the LSB end: word = {word[DATA_W-9:0], byte_in}, so the first byte lands in the MSB.
    - Byte index increments on each accept.
    - On the NBYTES-th accept, index returns to 0 and the next state is WRITE.
  - WRITE (exactly 1 cycle):
    - cfg_wen=1 and cfg_data=assembled word, both driven from registers; byte_ready=0; busy=1.
    - Next state is CHECK.
  - CHECK (exactly 1 cycle):
    - cfg_wen=0, busy=1; cfg_rdata now reflects the register after the write edge.
    - On exit: ok <= (cfg_rdata == cfg_data); done <= 1 for one cycle; if the readback mismatches, err_cnt increments.
    - Next state is COLLECT.
- Latency: the last byte is accepted at edge N; cfg_wen is high in cycle N..N+1; done/ok are visible in cycle N+2..N+3.
- Throughput: minimum NBYTES+2 cycles per word. byte_ready returns high in the same cycle done pulses, so back-to-back words are possible.
- cfg_data holds the last written word between writes; cfg_wen is never high for more than one cycle.
- byte_valid while byte_ready=0: the byte is not consumed; the source must hold it.
- A mismatch (write rejected by the register, e.g. in operation mode) is not retried; it is reported only via ok=0 and err_cnt.
- err_cnt saturates at all-ones.
- Reset mid-word or mid-WRITE/CHECK: the partial word is discarded, no done pulse is issued, and all outputs return to their reset values immediately.

Optional Feature:
CFG_LOADER_TIMEOUT_EN
- Defined:
  - An idle counter runs while in COLLECT with byte index != 0 and no byte accepted.
  - When the counter reaches TIMEOUT_CYCLES, the partial word and index are cleared, done pulses with ok=0, and err_cnt increments; no cfg_wen is issued.
  - The counter clears on every accepted byte.
- Undefined: no counter logic exists, and a partial word waits indefinitely.

Test Plan:
- Reset then bytes CA,FE,CA,F0 back-to-back:
  - cfg_wen pulses exactly 1 cycle with cfg_data=32'hCAFECAF0.
  - With a model register accepting the write, done=1 and ok=1 two cycles after the 4th byte; err_cnt=0.
- Word 32'hCAFECAFF sent while the model register ignores writes (cfg_rdata stays 32'hCAFECAF1): done=1, ok=0, err_cnt=1.
- byte_valid held high continuously across two words 11223344 and 55667788:
  - byte_ready is low for exactly 2 cycles per word.
  - Two cfg_wen pulses with the correct data, and no bytes are lost.
- rst asserted after 2 bytes, released, then bytes FA,CE,FA,C1: a single write of 32'hFACEFAC1 occurs, with no stale bytes in the word.
- Force 256 rejected writes: err_cnt reads 8'hFF and stays there.
- With CFG_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10, send 2 bytes then idle for 12 cycles:
  - done=1 with ok=0, err_cnt=1, and no cfg_wen.
  - A following full 4-byte word is written correctly.
